apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter ADDR_W, 32, APB address width.
REQ-002 Parameter DATA_W, 32, APB data width; legal values 8, 16, 32.
REQ-003 Parameter SLV_BITS, 2, slave-select bits; NUM_SLV = 2**SLV_BITS.
REQ-004 Parameter TMO_CYC, 16, maximum ACCESS cycles before timeout; 0 disables the timeout.
REQ-005 PCLK  in  1  APB clock; all state changes on its rising edge.
REQ-006 PRESETn  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  byte address; top SLV_BITS bits select the slave.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 cmd_strb  in  DATA_W/8  write byte strobes.
REQ-013 rsp_valid  out  1  one-cycle response pulse (no backpressure).
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
REQ-015 rsp_err  out  1  PSLVERR or timeout.
REQ-016 rsp_tmo  out  1  timeout occurred.
REQ-017 PSEL  out  NUM_SLV  one-hot slave select.
REQ-018 PENABLE, PWRITE  out  1 each  APB control signals.
REQ-019 PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8.
REQ-020 PREADY, PSLVERR  in  NUM_SLV each  per-slave completion and error.
REQ-021 PRDATA  in  NUM_SLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-022 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-023 IDLE: PSEL=0, PENABLE=0, cmd_ready=1; on cmd_valid, latch write/addr/wdata/strb and go to SETUP.
REQ-024 SETUP: PSEL[sel]=1, PENABLE=0, cmd_ready=0; unconditionally go to ACCESS next cycle.
REQ-025 ACCESS: PSEL[sel]=1, PENABLE=1; stay until PREADY[sel]=1 or timeout.
REQ-026 sel SHALL equal the latched addr[ADDR_W-1 -: SLV_BITS].
REQ-027 Only PREADY[sel], PSLVERR[sel] and PRDATA[sel] are observed; other slaves' inputs are ignored.
REQ-028 A transfer completes in the ACCESS cycle where PREADY[sel]=1; minimum latency is acceptance to completion in 2 cycles.
REQ-029 In the completion cycle cmd_ready=1, combinational from PREADY[sel].
  - cmd_valid=1 in that cycle: latch the new command and go directly to SETUP (back-to-back, no IDLE gap).
  - otherwise: go to IDLE.
REQ-030 Timeout (TMO_CYC>0): a wait counter increments each ACCESS cycle with PREADY[sel]=0.
  - When it reaches TMO_CYC, the transfer terminates: next state IDLE, PSEL and PENABLE deasserted.
  - cmd_ready=0 in the timeout cycle.
REQ-031 The wait counter SHALL clear on entry to SETUP.
REQ-032 The wait counter SHALL be $clog2(TMO_CYC+1) bits wide and SHALL NOT wrap.
REQ-033 PREADY[sel]=1 in the same cycle the counter reaches TMO_CYC counts as a normal completion, not a timeout.
REQ-034 rsp_valid SHALL pulse for one cycle, registered, in the cycle after completion or timeout.
REQ-035 Response fields:
  - rsp_err = PSLVERR[sel] on completion, or 1 on timeout.
  - rsp_tmo = 1 only on timeout.
  - rsp_rdata = PRDATA[sel] on read completion, else 0.
REQ-036 PADDR, PWRITE, PWDATA and PSTRB SHALL be stable from SETUP through the completion cycle, and SHALL hold their last values in IDLE.
REQ-037 PSTRB SHALL be all zeros for reads.
REQ-038 Exactly one PSEL bit SHALL be high in SETUP and ACCESS.

Reset
REQ-039 PRESETn low SHALL immediately force state IDLE.
REQ-040 PRESETn low SHALL immediately drive to 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, and the wait counter.
REQ-041 Reset mid-transfer SHALL discard the transfer with no response pulse.
REQ-042 cmd_ready SHALL be 1 after reset release, since the block is in IDLE.

Structure
REQ-043 Package apb_pkg SHALL hold the state enum apb_state_e {IDLE, SETUP, ACCESS} and the response record type (rdata, err, tmo).
REQ-044 The wait counter and timeout compare SHALL be a sub-module apb_wait_timer (TMO_CYC parameter; clear, inc and expired ports).

Verification
REQ-045 Single write, addr 0x4000_0010 (slave 1), wdata 0xDEADBEEF, strb 0xF, PREADY=1 in first ACCESS:
  - PSEL=4'b0010 for 2 cycles, PENABLE high in the 2nd.
  - rsp_valid one cycle later with rsp_err=0 and rsp_rdata=0.
REQ-046 Read from slave 3, 3 wait states, PRDATA=0x12345678:
  - ACCESS lasts 4 cycles with PADDR stable and PSTRB=0.
  - rsp_rdata=0x12345678.
REQ-047 Back-to-back write then read with cmd_valid held high:
  - second SETUP directly follows first completion; no IDLE cycle.
REQ-048 PREADY never asserted, TMO_CYC=16:
  - termination after 16 ACCESS cycles with rsp_err=1, rsp_tmo=1, PSEL=0.
  - PREADY arriving exactly at cycle 16 gives a normal completion instead.
REQ-049 PSLVERR=1 with PREADY=1 on slave 2 gives rsp_err=1 and rsp_tmo=0.
REQ-050 PRESETn low during ACCESS:
  - all outputs 0 asynchronously and no rsp_valid.
  - after release, cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB command master: FSM state encoding and the
// registered response record.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    // Widest legal data bus; narrower instances use the low bits.
    localparam int RSP_DATA_W = 32;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
        logic                  tmo;
    } apb_rsp_t;

    function automatic int tmo_cnt_w(input int tmo_cyc);
        return (tmo_cyc > 0) ? $clog2(tmo_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter. expired fires in the cycle the count would
// reach TMO_CYC; the counter saturates instead of wrapping.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TMO_CYC = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = tmo_cnt_w(TMO_CYC);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TMO_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && cnt != CNT_MAX)
            cnt <= cnt + CW'(1);
    end

    // TMO_CYC == 0 disables the timeout entirely.
    assign expired = (TMO_CYC > 0) && inc && (cnt == CNT_LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: turns valid/ready commands into APB
// SETUP/ACCESS transfers and returns a one-cycle registered response.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    parameter  int SLV_BITS = 2,
    parameter  int TMO_CYC  = 16,
    localparam int NUM_SLV  = 2**SLV_BITS,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [STRB_W-1:0]         cmd_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_tmo,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [STRB_W-1:0]         PSTRB,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA
);

    apb_state_e          state;
    apb_rsp_t            rsp_q;
    logic [SLV_BITS-1:0] sel;
    logic                pready_sel;
    logic                pslverr_sel;
    logic [DATA_W-1:0]   prdata_sel;
    logic                waiting;
    logic                done;
    logic                tmo;
    logic                accept;

    // PADDR holds the latched address, so it also supplies the slave index.
    assign sel         = PADDR[ADDR_W-1 -: SLV_BITS];
    assign pready_sel  = PREADY[sel];
    assign pslverr_sel = PSLVERR[sel];
    assign prdata_sel  = PRDATA[int'(sel)*DATA_W +: DATA_W];

    assign done      = (state == ACCESS) && pready_sel;
    assign waiting   = (state == ACCESS) && !pready_sel;
    assign cmd_ready = (state == IDLE) || done;
    assign accept    = cmd_valid && cmd_ready;

    apb_wait_timer #(.TMO_CYC(TMO_CYC)) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (accept),
        .inc     (waiting),
        .expired (tmo)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= '0;
        end else if (accept) begin
            // Covers both IDLE acceptance and back-to-back from completion.
            state   <= SETUP;
            PSEL    <= NUM_SLV'(1) << cmd_addr[ADDR_W-1 -: SLV_BITS];
            PENABLE <= 1'b0;
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            PWDATA  <= cmd_wdata;
            PSTRB   <= cmd_write ? cmd_strb : '0;
        end else begin
            case (state)
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (done || tmo) begin
                        state   <= IDLE;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            rsp_valid   <= done || tmo;
            rsp_q.err   <= done ? pslverr_sel : tmo;
            rsp_q.tmo   <= tmo;
            rsp_q.rdata <= (done && !PWRITE) ? RSP_DATA_W'(prdata_sel) : '0;
        end
    end

    assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err   = rsp_q.err;
    assign rsp_tmo   = rsp_q.tmo;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed scenarios plus random
// command streams checked cycle by cycle against a transfer-level model.
module tb_apb_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SB  = 2;
    localparam int TMO = 16;
    localparam int NS  = 4;
    localparam int SW  = 4;

    logic           PCLK = 1'b0;
    logic           PRESETn;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_wdata;
    logic [SW-1:0]  cmd_strb;
    logic           rsp_valid, rsp_err, rsp_tmo;
    logic [DW-1:0]  rsp_rdata;
    logic [NS-1:0]  PSEL;
    logic           PENABLE, PWRITE;
    logic [AW-1:0]  PADDR;
    logic [DW-1:0]  PWDATA;
    logic [SW-1:0]  PSTRB;
    logic [NS-1:0]  PREADY, PSLVERR;
    logic [NS*DW-1:0] PRDATA;

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .SLV_BITS(SB), .TMO_CYC(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;  // wait states before PREADY; >= TMO never answers
        bit          err;
        logic [31:0] rdata;
        bit          gap;    // 0: presented in the previous completion cycle
    } txn_t;

    int total = 0;
    int bad   = 0;

    function automatic txn_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] strb, int waits, bit err,
                                logic [31:0] rdata, bit gap);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
        t.waits = waits; t.err = err; t.rdata = rdata; t.gap = gap;
        return t;
    endfunction

    // Expected {rsp_valid, rsp_rdata, rsp_err, rsp_tmo} for one transfer.
    function automatic logic [34:0] exp_rsp(txn_t t);
        bit to;
        to = (t.waits >= TMO);
        return {1'b1, (to || t.wr) ? 32'h0 : t.rdata, to ? 1'b1 : t.err, to};
    endfunction

    task automatic drive_slaves(input int s, input bit rdy, input bit err, input logic [31:0] rd);
        PREADY  = 4'($urandom);
        PSLVERR = 4'($urandom);
        for (int j = 0; j < NS; j++) PRDATA[j*DW +: DW] = $urandom;
        if (s >= 0) begin
            PREADY[s] = rdy;
            PSLVERR[s] = err;
            PRDATA[s*DW +: DW] = rd;
        end
    endtask

    task automatic present(input txn_t t);
        cmd_valid = 1'b1; cmd_write = t.wr; cmd_addr = t.addr;
        cmd_wdata = t.wdata; cmd_strb = t.strb;
    endtask

    task automatic scramble_cmd();
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    endtask

    // Runs a command stream; starts from IDLE, ends in IDLE.
    task automatic run_seq(input txn_t q[$], input string tag);
        int n;
        bit prev_b2b;
        logic [75:0] obs, exp;
        logic [74:0] iobs, iexp;
        logic [34:0] robs, rexp;
        n = q.size();
        prev_b2b = 1'b0;
        @(negedge PCLK);
        present(q[0]); drive_slaves(-1, 1'b0, 1'b0, 32'h0); #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s idle_ready: got %b want 1", tag, cmd_ready); end
        @(posedge PCLK); @(negedge PCLK);
        for (int i = 0; i < n; i++) begin
            txn_t t;
            int s;
            bit to, b2b;
            logic [3:0] oh, ps;
            t = q[i];
            s = int'(t.addr[31:30]);
            to = (t.waits >= TMO);
            oh = 4'(1) << s;
            ps = t.wr ? t.strb : 4'h0;
            b2b = (i + 1 < n) && !q[i+1].gap && !to;
            scramble_cmd(); drive_slaves(-1, 1'b0, 1'b0, 32'h0); #1;
            obs = {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, cmd_ready, rsp_valid};
            exp = {oh, 1'b0, t.addr, t.wr, t.wdata, ps, 1'b0, prev_b2b};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL %s[%0d] setup: got %h want %h", tag, i, obs, exp); end
            for (int k = 1; k <= TMO; k++) begin
                bit dn;
                dn = (k == t.waits + 1);
                @(posedge PCLK); @(negedge PCLK);
                drive_slaves(s, dn, t.err, t.rdata);
                if (dn && b2b) present(q[i+1]);
                #1;
                obs = {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, cmd_ready, rsp_valid};
                exp = {oh, 1'b1, t.addr, t.wr, t.wdata, ps, dn, 1'b0};
                total++;
                if (obs !== exp) begin bad++; $display("FAIL %s[%0d] access%0d: got %h want %h", tag, i, k, obs, exp); end
                if (dn) break;
            end
            @(posedge PCLK); @(negedge PCLK);
            if (!b2b) drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            #1;
            robs = {rsp_valid, rsp_rdata, rsp_err, rsp_tmo};
            rexp = exp_rsp(t);
            total++;
            if (robs !== rexp) begin bad++; $display("FAIL %s[%0d] rsp: got %h want %h", tag, i, robs, rexp); end
            if (!b2b) begin
                iobs = {PSEL, PENABLE, cmd_ready, PADDR, PWRITE, PWDATA, PSTRB};
                iexp = {4'h0, 1'b0, 1'b1, t.addr, t.wr, t.wdata, ps};
                total++;
                if (iobs !== iexp) begin bad++; $display("FAIL %s[%0d] idle: got %h want %h", tag, i, iobs, iexp); end
                if (i + 1 < n) begin
                    present(q[i+1]);
                    @(posedge PCLK); @(negedge PCLK);
                end
            end
            prev_b2b = b2b;
        end
        @(negedge PCLK); #1;
        total++;
        if ({rsp_valid, PSEL} !== 5'b0) begin bad++; $display("FAIL %s tail: got rsp_valid=%b PSEL=%b want 0", tag, rsp_valid, PSEL); end
    endtask

    task automatic test_reset();
        logic [109:0] obs;
        PRESETn = 1'b0; scramble_cmd(); drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        #1;
        obs = {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, cmd_ready};
        total++;
        if (obs !== 110'h1) begin bad++; $display("FAIL reset_outputs: got %h want 1", obs); end
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK); #1;
        total++;
        if ({cmd_ready, PSEL, rsp_valid} !== 6'b100000) begin
            bad++; $display("FAIL reset_release: got ready=%b psel=%b rsp=%b want 1/0000/0", cmd_ready, PSEL, rsp_valid);
        end
    endtask

    task automatic test_single_write();
        txn_t q[$];
        q.push_back(mk(1'b1, 32'h4000_0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'hA5A5_5A5A, 1'b1));
        run_seq(q, "single_write");
    endtask

    task automatic test_read_wait();
        txn_t q[$];
        q.push_back(mk(1'b0, 32'hC000_0020, 32'h1111_2222, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b1));
        run_seq(q, "read_wait");
    endtask

    task automatic test_back_to_back();
        txn_t q[$];
        q.push_back(mk(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h3, 0, 1'b0, 32'h0, 1'b1));
        q.push_back(mk(1'b0, 32'h8000_0200, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_CAFE, 1'b0));
        q.push_back(mk(1'b0, 32'h4000_0300, 32'h0, 4'h0, 0, 1'b0, 32'h7777_8888, 1'b0));
        run_seq(q, "back_to_back");
    endtask

    task automatic test_timeout();
        txn_t q[$];
        q.push_back(mk(1'b0, 32'h4000_0040, 32'h0, 4'hF, 1000, 1'b0, 32'hFFFF_FFFF, 1'b1));
        q.push_back(mk(1'b0, 32'h4000_0044, 32'h0, 4'hF, TMO - 1, 1'b0, 32'h5566_7788, 1'b0));
        q.push_back(mk(1'b1, 32'hC000_0048, 32'h1, 4'h1, TMO, 1'b0, 32'h0, 1'b0));
        run_seq(q, "timeout");
    endtask

    task automatic test_slverr();
        txn_t q[$];
        q.push_back(mk(1'b1, 32'h8000_0008, 32'h0102_0304, 4'hC, 0, 1'b1, 32'h0, 1'b1));
        q.push_back(mk(1'b0, 32'h8000_000C, 32'h0, 4'hF, 2, 1'b1, 32'h9999_0000, 1'b1));
        run_seq(q, "slverr");
    endtask

    task automatic test_random();
        txn_t q[$];
        for (int i = 0; i < 40; i++) begin
            int r, w;
            r = int'($urandom_range(0, 9));
            w = (r == 9) ? TMO + int'($urandom_range(0, 3)) : (r == 8) ? TMO - 1 : int'($urandom_range(0, 4));
            q.push_back(mk(1'($urandom), $urandom, $urandom, 4'($urandom), w,
                           1'($urandom), $urandom, 1'($urandom)));
        end
        run_seq(q, "random");
    endtask

    task automatic test_reset_mid();
        txn_t q[$];
        logic [108:0] obs;
        q.push_back(mk(1'b1, 32'h4000_0050, 32'h1357_9BDF, 4'hF, 5, 1'b0, 32'h0, 1'b1));
        @(negedge PCLK); present(q[0]); drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        @(posedge PCLK); @(negedge PCLK); scramble_cmd();
        @(posedge PCLK); @(negedge PCLK); drive_slaves(1, 1'b0, 1'b0, 32'h0);
        #2 PRESETn = 1'b0;
        #1;
        obs = {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_tmo};
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_mid_async: got %h want 0", obs); end
        @(negedge PCLK); drive_slaves(1, 1'b1, 1'b0, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        drive_slaves(1, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge PCLK); #1;
            total++;
            if ({rsp_valid, cmd_ready, PSEL} !== 6'b010000) begin
                bad++; $display("FAIL reset_mid_after%0d: got rsp=%b ready=%b psel=%b want 0/1/0000", c, rsp_valid, cmd_ready, PSEL);
            end
        end
        q.delete();
        q.push_back(mk(1'b0, 32'h0000_0060, 32'h0, 4'hF, 1, 1'b0, 32'h2468_ACE0, 1'b1));
        run_seq(q, "post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        PREADY = '0; PSLVERR = '0; PRDATA = '0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
